// File: rtl/shrink_pulse_if.sv
// Pulse-shrinker port bundle: raw level in, debounced strobes, level and held width out.
// The slave modport is the shrink_pulse side; master is whoever drives large_pulse.
interface shrink_pulse_if #(
   parameter int unsigned PULSE_SIZE = 16
);
   logic                  large_pulse;
   logic                  small_pulse;
   logic                  release_pulse;
   logic                  level_out;
   logic [PULSE_SIZE-1:0] width_out;
   logic                  width_valid;

   modport master (
      output large_pulse,
      input  small_pulse,
      input  release_pulse,
      input  level_out,
      input  width_out,
      input  width_valid
   );

   modport slave (
      input  large_pulse,
      output small_pulse,
      output release_pulse,
      output level_out,
      output width_out,
      output width_valid
   );
endinterface

// File: rtl/shrink_pulse.sv
// Debounces an asynchronous level, turning each accepted pulse into rise/release strobes
// and reporting how many cycles the debounced level was held.
module shrink_pulse #(
   parameter int unsigned DEBOUNCE_CYCLES = 256,
   parameter int unsigned PULSE_SIZE      = 16
) (
   input  logic          clk,
   input  logic          rst,
   shrink_pulse_if.slave io_pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRiseChk,
      StHigh,
      StFallChk
   } state_e;

   state_e                r_state;
   logic                  r_sync1;
   logic                  r_sync2;
   logic [CntW-1:0]       r_cnt;
   logic [PULSE_SIZE-1:0] r_width_cnt;
   logic                  r_small;
   logic                  r_release;
   logic                  r_level;
   logic [PULSE_SIZE-1:0] r_width_out;
   logic                  r_width_valid;

   logic                  w_sync_in;
   logic [PULSE_SIZE-1:0] w_width_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= io_pulse.large_pulse;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sync_in   = r_sync2;
   // Held width saturates rather than wrapping on very long pulses.
   assign w_width_inc = (r_width_cnt == '1) ? r_width_cnt : r_width_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_width_cnt   <= '0;
         r_small       <= 1'b0;
         r_release     <= 1'b0;
         r_level       <= 1'b0;
         r_width_out   <= '0;
         r_width_valid <= 1'b0;
      end else begin
         r_small       <= 1'b0;
         r_release     <= 1'b0;
         r_width_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_sync_in) begin
                  r_state <= StRiseChk;
                  r_cnt   <= '0;
               end
            end
            StRiseChk: begin
               if (!w_sync_in) begin
                  r_state <= StIdle;
               end else if (r_cnt == CntLast) begin
                  r_state     <= StHigh;
                  r_small     <= 1'b1;
                  r_level     <= 1'b1;
                  r_width_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StHigh: begin
               r_width_cnt <= w_width_inc;
               if (!w_sync_in) begin
                  r_state <= StFallChk;
                  r_cnt   <= '0;
               end
            end
            StFallChk: begin
               // A short low run is a bounce: the pulse and its width carry on.
               if (w_sync_in) begin
                  r_state     <= StHigh;
                  r_width_cnt <= w_width_inc;
               end else if (r_cnt == CntLast) begin
                  r_state       <= StIdle;
                  r_release     <= 1'b1;
                  r_level       <= 1'b0;
                  r_width_out   <= r_width_cnt;
                  r_width_valid <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + 1'b1;
                  r_width_cnt <= w_width_inc;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_pulse.small_pulse   = r_small;
   assign io_pulse.release_pulse = r_release;
   assign io_pulse.level_out     = r_level;
   assign io_pulse.width_out     = r_width_out;
   assign io_pulse.width_valid   = r_width_valid;

endmodule

// File: tb/tb_shrink_pulse.sv
// Bench for shrink_pulse: directed and random level sequences checked cycle by cycle
// against a run-length reference model of the debounced pulse.
module tb_shrink_pulse;
   localparam int unsigned D    = 4;
   localparam int unsigned P    = 8;
   localparam int          WMax = (1 << P) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   shrink_pulse_if #(.PULSE_SIZE(P)) u_if ();

   shrink_pulse #(
      .DEBOUNCE_CYCLES(D),
      .PULSE_SIZE     (P)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .io_pulse(u_if)
   );

   always #5 clk = ~clk;

   // Model: level is confirmed after D+1 consecutive opposite synchronized samples.
   bit m_s1, m_s2, m_level;
   int m_run, m_cyc, m_rise_cyc, m_wout;
   bit e_sp, e_rp, e_wv;
   int sp_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_wout = 0;
      e_sp = 0; e_rp = 0; e_wv = 0;
   endtask

   task automatic model_step();
      bit x;
      x    = m_s2;
      m_s2 = m_s1;
      m_s1 = u_if.large_pulse;
      e_sp = 0; e_rp = 0; e_wv = 0;
      if (x != m_level) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
         m_level = x;
         m_run   = 0;
         if (x) begin
            e_sp       = 1;
            m_rise_cyc = m_cyc;
         end else begin
            e_rp   = 1;
            e_wv   = 1;
            m_wout = m_cyc - m_rise_cyc - 1;
            if (m_wout > WMax) m_wout = WMax;
         end
      end
   endtask

   task automatic check_outputs(input string ph);
      check({ph, "/small_pulse"},   u_if.small_pulse,   e_sp);
      check({ph, "/release_pulse"}, u_if.release_pulse, e_rp);
      check({ph, "/width_valid"},   u_if.width_valid,   e_wv);
      check({ph, "/level_out"},     u_if.level_out,     m_level);
      check({ph, "/width_out"},     u_if.width_out,     m_wout);
   endtask

   task automatic run(input bit v, input int n, input string ph);
      for (int i = 0; i < n; i++) begin
         u_if.large_pulse = v;
         @(posedge clk);
         m_cyc++;
         if (rst) model_reset();
         else model_step();
         #1;
         if (u_if.small_pulse === 1'b1) sp_cyc = m_cyc;
         check_outputs(ph);
      end
   endtask

   task automatic check_all_zero(input string ph);
      check({ph, "/small_pulse"},   u_if.small_pulse,   0);
      check({ph, "/release_pulse"}, u_if.release_pulse, 0);
      check({ph, "/width_valid"},   u_if.width_valid,   0);
      check({ph, "/level_out"},     u_if.level_out,     0);
      check({ph, "/width_out"},     u_if.width_out,     0);
   endtask

   initial begin
      int e0;
      int len;
      bit v;
      m_cyc      = 0;
      m_rise_cyc = 0;
      sp_cyc     = -1;
      model_reset();
      u_if.large_pulse = 1'b0;

      // Reset asserted between clock edges must clear outputs at once.
      #2 rst = 1'b1;
      #1 check_all_zero("reset_async");
      run(0, 3, "reset_hold");
      rst = 1'b0;
      check("reset_release/level_out", u_if.level_out, 0);
      run(0, 3, "idle");

      // Clean 20-cycle pulse.
      e0 = m_cyc + 1;
      run(1, 20, "clean_high");
      run(0, 10, "clean_low");
      check("clean_rise_latency", sp_cyc - e0, 2 + D);
      check("clean_width", u_if.width_out, 19);

      // Glitch shorter than the debounce window.
      run(1, 3, "glitch_high");
      run(0, 10, "glitch_low");

      // Bounce inside an accepted pulse.
      run(1, 15, "bounce_high1");
      run(0, 2,  "bounce_low");
      run(1, 10, "bounce_high2");
      run(0, 10, "bounce_tail");
      check("bounce_width", u_if.width_out, 26);

      // Saturation of the held width.
      run(1, 400, "sat_high");
      run(0, 10,  "sat_low");
      check("sat_width", u_if.width_out, WMax);

      // Random run lengths straddling the debounce threshold.
      v = 1'b1;
      for (int s = 0; s < 60; s++) begin
         len = $urandom_range(1, 14);
         run(v, len, "random");
         v = ~v;
      end
      run(0, 12, "random_tail");

      // Reset in the middle of an accepted pulse.
      run(1, 10, "mid_high");
      check("mid_level_before_rst", u_if.level_out, 1);
      #2 rst = 1'b1;
      #1 check_all_zero("mid_rst_async");
      model_reset();
      run(1, 2, "mid_rst_hold");
      rst    = 1'b0;
      sp_cyc = -1;
      e0     = m_cyc + 1;
      run(1, 12, "mid_rerise");
      check("mid_rerise_latency", sp_cyc - e0, 2 + D);
      run(0, 10, "mid_tail");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
